ps2_key_ctrl: RTL and testbench

Scan-code sequencer between the PS/2 receiver's output FIFO and keyboard consumers (display, counters, CPU MMIO). It pops bytes from the receiver with a one-cycle strobe and folds the E0/E1/F0 prefixes into single key events. Each event is presented on a valid/ready port. It tracks the currently held key, suppresses typematic repeats from the press count, and flags protocol/overflow errors.

---
 rtl/ps2_key_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns the PS/2 receiver's byte stream into single key events.
// Folds E0/F0/E1 prefixes, tracks the held key, suppresses typematic repeats
// from the press counter and raises a sticky error on protocol or FIFO faults.
module ps2_key_ctrl #(
    parameter int PAUSE_LEN = 7
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_pop,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [7:0] press_cnt,
    output logic       err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GOT_E0   = 3'd1;
    localparam logic [2:0] GOT_F0   = 3'd2;
    localparam logic [2:0] GOT_E0F0 = 3'd3;
    localparam logic [2:0] PAUSE    = 3'd4;
    localparam logic [2:0] EMIT     = 3'd5;

    logic [2:0] state_reg, state_next;
    logic [7:0] skip_reg, skip_next;
    logic       pop_next;
    logic       handshake;
    logic       is_prefix, is_bad;
    logic       emit_go, emit_ext, emit_brk;
    logic [7:0] emit_code;
    logic       proto_err;
    logic       emit_match;
    logic       evt_is_pause;

    assign evt_valid    = (state_reg == EMIT);
    assign handshake    = evt_valid && evt_ready;
    assign is_prefix    = (kbd_data == 8'hE0) || (kbd_data == 8'hE1) || (kbd_data == 8'hF0);
    assign is_bad       = (kbd_data == 8'h00) || (kbd_data == 8'hFF);
    assign emit_match   = key_down && (held_code == emit_code) && (held_ext == emit_ext);
    assign evt_is_pause = (evt_code == 8'hE1) && !evt_ext;

    // The pop decision is registered; it never fires two cycles in a row so the
    // receiver can advance its head, and it may fire right after a handshake.
    assign pop_next = kbd_ready && !kbd_pop && ((state_reg != EMIT) || handshake);

    // Decode the byte consumed this cycle (kbd_pop high) into the next state.
    always_comb begin
        state_next = state_reg;
        skip_next  = skip_reg;
        emit_go    = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        emit_code  = kbd_data;
        proto_err  = 1'b0;
        case (state_reg)
            IDLE: if (kbd_pop) begin
                if (kbd_data == 8'hE0) begin
                    state_next = GOT_E0;
                end else if (kbd_data == 8'hF0) begin
                    state_next = GOT_F0;
                end else if (kbd_data == 8'hE1) begin
                    state_next = PAUSE;
                    skip_next  = 8'(PAUSE_LEN);
                end else if (is_bad) begin
                    proto_err = 1'b1;
                end else begin
                    emit_go = 1'b1;
                end
            end
            GOT_E0: if (kbd_pop) begin
                if (kbd_data == 8'hF0) begin
                    state_next = GOT_E0F0;
                end else if (is_prefix || is_bad) begin
                    proto_err  = 1'b1;
                    state_next = IDLE;
                end else begin
                    emit_go  = 1'b1;
                    emit_ext = 1'b1;
                end
            end
            GOT_F0: if (kbd_pop) begin
                if (is_prefix || is_bad) begin
                    proto_err  = 1'b1;
                    state_next = IDLE;
                end else begin
                    emit_go  = 1'b1;
                    emit_brk = 1'b1;
                end
            end
            GOT_E0F0: if (kbd_pop) begin
                if (is_prefix || is_bad) begin
                    proto_err  = 1'b1;
                    state_next = IDLE;
                end else begin
                    emit_go  = 1'b1;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
            end
            PAUSE: if (kbd_pop) begin
                skip_next = skip_reg - 8'd1;
                if (skip_reg <= 8'd1) begin
                    skip_next = 8'd0;
                    emit_go   = 1'b1;
                    emit_code = 8'hE1;
                end
            end
            EMIT: if (handshake) begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (emit_go) begin
            state_next = EMIT;
        end
    end

    // Sequencer state, pause skip counter, pop strobe and sticky error.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            skip_reg  <= 8'd0;
            kbd_pop   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= skip_next;
            kbd_pop   <= pop_next;
            if (kbd_overflow || proto_err) begin
                err <= 1'b1;
            end
        end
    end

    // Capture event fields on entry to EMIT; repeat is judged against the held key now.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evt_code   <= 8'd0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
        end else if (emit_go) begin
            evt_code   <= emit_code;
            evt_ext    <= emit_ext;
            evt_break  <= emit_brk;
            evt_repeat <= !emit_brk && emit_match;
        end
    end

    // Held-key tracking and press counting, applied on the consumer handshake.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_down  <= 1'b0;
            held_code <= 8'd0;
            held_ext  <= 1'b0;
            press_cnt <= 8'd0;
        end else if (handshake) begin
            if (!evt_break) begin
                if (!evt_repeat) begin
                    press_cnt <= press_cnt + 8'd1;
                    if (!evt_is_pause) begin
                        key_down  <= 1'b1;
                        held_code <= evt_code;
                        held_ext  <= evt_ext;
                    end
                end
            end else if (key_down && (held_code == evt_code) && (held_ext == evt_ext)) begin
                key_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: scoreboard bench. Stimulus pushes bytes into a modelled
// receiver FIFO and expected events (from a byte-stream reference model) into
// a queue; a negedge monitor pops and compares on every event handshake.
module tb_ps2_key_ctrl;

    localparam int PAUSE_LEN = 7;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kbd_data = 8'd0;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_pop;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break, evt_repeat, key_down, held_ext, err;
    logic [7:0] held_code, press_cnt;

    ps2_key_ctrl #(.PAUSE_LEN(PAUSE_LEN)) dut (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_pop(kbd_pop), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .evt_repeat(evt_repeat), .key_down(key_down),
        .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext, brk, rep, kd;
        logic [7:0] hc;
        logic       he;
        logic [7:0] cnt;
    } ev_t;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] fifo_q[$];
    ev_t        exp_q[$];
    logic       stall = 1'b0;
    logic       pop_seen = 1'b0;
    logic       pending_post = 1'b0;
    logic [7:0] codes[5] = '{8'h1C, 8'h1B, 8'h75, 8'h23, 8'h5A};

    // Reference model state: prefix flags, pause countdown, held key, counter, error.
    logic       m_e0, m_f0, m_kd, m_he, m_err;
    int         m_pause;
    logic [7:0] m_hc, m_cnt;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_kd = 0; m_he = 0; m_err = 0;
        m_pause = 0; m_hc = 8'd0; m_cnt = 8'd0;
    endtask

    task automatic model_emit(input logic [7:0] code, input logic ext, input logic brk,
                              input logic pause);
        ev_t  e;
        logic match;
        match = m_kd && (m_hc == code) && (m_he == ext);
        e.code = code; e.ext = ext; e.brk = brk; e.rep = !brk && match;
        if (brk) begin
            if (match) m_kd = 0;
        end else if (!e.rep) begin
            m_cnt = m_cnt + 8'd1;
            if (!pause) begin
                m_kd = 1; m_hc = code; m_he = ext;
            end
        end
        e.kd = m_kd; e.hc = m_hc; e.he = m_he; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_emit(8'hE1, 1'b0, 1'b0, 1'b1);
        end else if (b == 8'hE1) begin
            if (!m_e0 && !m_f0) m_pause = PAUSE_LEN;
            else begin m_err = 1; m_e0 = 0; m_f0 = 0; end
        end else if (b == 8'hE0) begin
            if (!m_e0 && !m_f0) m_e0 = 1;
            else begin m_err = 1; m_e0 = 0; m_f0 = 0; end
        end else if (b == 8'hF0) begin
            if (!m_f0) m_f0 = 1;
            else begin m_err = 1; m_e0 = 0; m_f0 = 0; end
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_err = 1; m_e0 = 0; m_f0 = 0;
        end else begin
            model_emit(b, m_e0, m_f0, 1'b0);
            m_e0 = 0; m_f0 = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    // Receiver FIFO model: drop the head after a consumed cycle, then present the new head.
    always @(negedge clk) pop_seen = kbd_pop;
    always @(posedge clk) begin
        #1;
        if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
        kbd_ready = (fifo_q.size() != 0);
        kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'd0;
    end

    // Consumer: random backpressure unless a stall is requested.
    always @(posedge clk) begin
        #1;
        evt_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop spacing, event stability, scoreboard compare, post-handshake state.
    ev_t        cur;
    logic       prev_valid = 1'b0, prev_hs = 1'b0, prev_pop = 1'b0;
    logic [10:0] prev_fields = 11'd0;
    always @(negedge clk) begin
        if (!clrn) begin
            prev_valid = 0; prev_hs = 0; prev_pop = 0; pending_post = 0;
        end else begin
            if (pending_post) begin
                chk1("post_key_down", key_down, cur.kd);
                chk8("post_held_code", held_code, cur.hc);
                chk1("post_held_ext", held_ext, cur.he);
                chk8("post_press_cnt", press_cnt, cur.cnt);
                pending_post = 0;
            end
            if (kbd_pop) chk1("pop_not_adjacent", prev_pop, 1'b0);
            if (prev_valid && !prev_hs) begin
                chk1("valid_held", evt_valid, 1'b1);
                n_checks++;
                if ({evt_code, evt_ext, evt_break, evt_repeat} !== prev_fields) begin
                    n_fail++;
                    $display("FAIL evt_stable: got %0h expected %0h",
                             {evt_code, evt_ext, evt_break, evt_repeat}, prev_fields);
                end
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got code %0h ext %0b brk %0b expected none",
                             evt_code, evt_ext, evt_break);
                end else begin
                    cur = exp_q.pop_front();
                    chk8("evt_code", evt_code, cur.code);
                    chk1("evt_ext", evt_ext, cur.ext);
                    chk1("evt_break", evt_break, cur.brk);
                    chk1("evt_repeat", evt_repeat, cur.rep);
                    $display("event code=%02h ext=%0b brk=%0b rep=%0b cnt_exp=%0d",
                             evt_code, evt_ext, evt_break, evt_repeat, cur.cnt);
                    pending_post = 1;
                end
            end
            prev_valid  = evt_valid;
            prev_hs     = evt_valid && evt_ready;
            prev_pop    = kbd_pop;
            prev_fields = {evt_code, evt_ext, evt_break, evt_repeat};
        end
    end

    task automatic drain();
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || evt_valid || pending_post) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk1("drain_in_time", (t < 5000), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 clrn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        fifo_q.delete();
        exp_q.delete();
        model_reset();
        @(negedge clk);
        chk1("rst_kbd_pop", kbd_pop, 1'b0);
        chk1("rst_evt_valid", evt_valid, 1'b0);
        chk8("rst_evt_code", evt_code, 8'd0);
        chk1("rst_evt_ext", evt_ext, 1'b0);
        chk1("rst_evt_break", evt_break, 1'b0);
        chk1("rst_evt_repeat", evt_repeat, 1'b0);
        chk1("rst_key_down", key_down, 1'b0);
        chk8("rst_held_code", held_code, 8'd0);
        chk1("rst_held_ext", held_ext, 1'b0);
        chk8("rst_press_cnt", press_cnt, 8'd0);
        chk1("rst_err", err, 1'b0);
        @(posedge clk);
        #1 clrn = 1'b1;
    endtask

    task automatic pulse_overflow();
        @(posedge clk);
        #1 kbd_overflow = 1'b1;
        @(posedge clk);
        #1 kbd_overflow = 1'b0;
        m_err = 1;
        @(negedge clk);
        chk1("err_after_overflow", err, m_err);
    endtask

    initial begin
        int t;
        logic [7:0] k;
        int a;
        model_reset();
        do_reset();

        // make/break of one key
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        // typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        // extended key
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain();
        // Pause sequence
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain();
        chk1("err_clean", err, m_err);

        // backpressure: event held, receiver stalled
        stall = 1'b1;
        @(posedge clk);
        #2;
        send(8'h1B); send(8'h2C); send(8'h3A);
        t = 0;
        while (!evt_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk1("stall_event_seen", evt_valid, 1'b1);
        repeat (20) @(negedge clk);
        chk1("stall_valid", evt_valid, 1'b1);
        chk8("stall_fifo_level", 8'(fifo_q.size()), 8'd2);
        stall = 1'b0;
        drain();

        // randomized key traffic
        for (int i = 0; i < 40; i++) begin
            k = codes[$urandom_range(0, 4)];
            a = $urandom_range(0, 9);
            if (a <= 3) begin
                send(k);
            end else if (a <= 6) begin
                send(8'hF0); send(k);
            end else if (a == 7) begin
                send(8'hE0); send(k);
            end else if (a == 8) begin
                send(8'hE0); send(8'hF0); send(k);
            end else begin
                send(8'hE1);
                for (int j = 0; j < PAUSE_LEN; j++) send(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        drain();
        chk1("err_after_random", err, m_err);

        // protocol error then recovery
        send(8'hF0); send(8'hF0); send(8'h1C);
        drain();
        chk1("err_protocol", err, m_err);
        pulse_overflow();

        // reset in the middle of a prefix sequence
        send(8'hE0); send(8'hF0);
        t = 0;
        while (fifo_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk1("prefix_consumed", (fifo_q.size() == 0), 1'b1);
        repeat (2) @(negedge clk);
        do_reset();
        send(8'h1C);
        drain();
        chk1("err_clean_after_reset", err, m_err);
        pulse_overflow();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
